// File: rtl/metadata_arbiter_pkg.sv
// Shared widths, latencies and FSM encoding for the note-metadata BRAM arbiter.
package metadata_arbiter_pkg;
  localparam int N_REQ_DEF   = 37;
  localparam int DATA_W      = 16;
  localparam int PTR_W       = 6;
  localparam int LANE_W      = 6;
  localparam int MEM_LAT     = 2;
  localparam int ADDR_W      = LANE_W + PTR_W;
  localparam int FLUSH_CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [LANE_W-1:0] lane,
                                                input logic [PTR_W-1:0]  ptr);
    return {lane, ptr};
  endfunction
endpackage

// File: rtl/metadata_arbiter_if.sv
// Scoring-block request/return bus plus BRAM read port; slave = arbiter side,
// master = scoring block, loader-owned BRAM and song control.
interface metadata_arbiter_if
  import metadata_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) ();
  logic                      pause;
  logic                      restart;
  logic [N_REQ-1:0]          metadata_request;
  logic [N_REQ*DATA_W-1:0]   metadata_link;
  logic [N_REQ-1:0]          metadata_available;
  logic                      busy;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_rd_en;
  logic [DATA_W-1:0]         mem_rd_data;

  modport slave (
    input  pause, restart, metadata_request, mem_rd_data,
    output metadata_link, metadata_available, busy, mem_addr, mem_rd_en
  );

  modport master (
    output pause, restart, metadata_request, mem_rd_data,
    input  metadata_link, metadata_available, busy, mem_addr, mem_rd_en
  );
endinterface

// File: rtl/metadata_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request above i_last, wrapping modulo N_REQ.
// Zero latency; o_any low when nothing requests.
module metadata_arbiter_rr_arbiter
  import metadata_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]  i_req,
  input  logic [LANE_W-1:0] i_last,
  output logic [N_REQ-1:0]  o_gnt,
  output logic [LANE_W-1:0] o_idx,
  output logic              o_any
);
  localparam logic [LANE_W:0] N_REQ_W = (LANE_W + 1)'(N_REQ);

  logic [LANE_W:0]   w_sum;
  logic [LANE_W-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_sum = '0;
    w_j   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_sum = {1'b0, i_last} + (LANE_W + 1)'(k);
      if (w_sum >= N_REQ_W) w_sum = w_sum - N_REQ_W;
      w_j = w_sum[LANE_W-1:0];
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_idx      = w_j;
        o_gnt[w_j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/metadata_arbiter.sv
// Shares one BRAM read port among N_REQ lanes; request-to-available is MEM_LAT+2 cycles.
// pause/FLUSH stop new grants only; a lane is re-granted once its pending read returns.
module metadata_arbiter
  import metadata_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input logic                clk,
  input logic                reset_n,
  metadata_arbiter_if.slave  bus
);
  state_t                            r_state;
  logic [FLUSH_CNT_W-1:0]            r_flush_cnt;
  logic [PTR_W-1:0]                  r_ptr [N_REQ];
  logic [N_REQ-1:0]                  r_pending;
  logic [N_REQ-1:0]                  r_avail;
  logic [N_REQ-1:0][DATA_W-1:0]      r_link;
  logic [LANE_W-1:0]                 r_rr_last;
  logic                              r_mem_rd_en;
  logic [ADDR_W-1:0]                 r_mem_addr;
  logic [MEM_LAT-1:0]                r_tag_vld;
  logic [LANE_W-1:0]                 r_tag_lane [MEM_LAT];

  logic [N_REQ-1:0]  w_elig;
  logic [N_REQ-1:0]  w_gnt;
  logic [N_REQ-1:0]  w_gnt_en;
  logic [N_REQ-1:0]  w_ret_oh;
  logic [LANE_W-1:0] w_win;
  logic [LANE_W-1:0] w_ret_lane;
  logic              w_any;
  logic              w_grant;
  logic              w_ret_vld;

  assign w_elig = bus.metadata_request & ~r_pending;

  metadata_arbiter_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req  (w_elig),
    .i_last (r_rr_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_win),
    .o_any  (w_any)
  );

  assign w_grant    = (r_state == ST_RUN) && !bus.pause && !bus.restart && w_any;
  assign w_gnt_en   = w_grant ? w_gnt : '0;
  assign w_ret_vld  = r_tag_vld[MEM_LAT-1];
  assign w_ret_lane = r_tag_lane[MEM_LAT-1];
  assign w_ret_oh   = w_ret_vld ? (N_REQ'(1) << w_ret_lane) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      for (int i = 0; i < N_REQ; i++) r_ptr[i] <= '0;
      r_pending   <= '0;
      r_avail     <= '0;
      r_link      <= '0;
      r_rr_last   <= LANE_W'(N_REQ - 1);
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_tag_vld   <= '0;
      for (int s = 0; s < MEM_LAT; s++) r_tag_lane[s] <= '0;
    end else begin
      r_mem_rd_en <= w_grant;
      if (w_grant) begin
        r_mem_addr     <= mk_addr(w_win, r_ptr[w_win]);
        r_ptr[w_win]   <= r_ptr[w_win] + 1'b1;
        r_rr_last      <= w_win;
      end

      // Tag travels with the read so the return lands in the lane that issued it.
      r_tag_vld[0]  <= r_mem_rd_en;
      r_tag_lane[0] <= r_mem_addr[PTR_W +: LANE_W];
      for (int s = 1; s < MEM_LAT; s++) begin
        r_tag_vld[s]  <= r_tag_vld[s-1];
        r_tag_lane[s] <= r_tag_lane[s-1];
      end

      r_pending <= (r_pending & ~w_ret_oh) | w_gnt_en;
      r_avail   <= (r_avail & ~w_gnt_en) | w_ret_oh;
      if (w_ret_vld) r_link[w_ret_lane] <= bus.mem_rd_data;

      case (r_state)
        ST_RUN:    if (bus.pause) r_state <= ST_PAUSED;
        ST_PAUSED: if (!bus.pause) r_state <= ST_RUN;
        ST_FLUSH: begin
          if (r_flush_cnt == FLUSH_CNT_W'(MEM_LAT)) r_state <= bus.pause ? ST_PAUSED : ST_RUN;
          else r_flush_cnt <= r_flush_cnt + 1'b1;
        end
        default:   r_state <= ST_RUN;
      endcase

      // Song restart drops all lane state and any reads still in the BRAM pipe.
      if (bus.restart) begin
        r_state     <= ST_FLUSH;
        r_flush_cnt <= '0;
        for (int i = 0; i < N_REQ; i++) r_ptr[i] <= '0;
        r_pending   <= '0;
        r_avail     <= '0;
        r_tag_vld   <= '0;
      end
    end
  end

  assign bus.mem_rd_en          = r_mem_rd_en;
  assign bus.mem_addr           = r_mem_addr;
  assign bus.metadata_available = r_avail;
  assign bus.metadata_link      = r_link;
  assign bus.busy               = (r_state == ST_FLUSH) || r_mem_rd_en || (|r_tag_vld);
endmodule

// File: tb/tb_metadata_arbiter.sv
// Directed bench for metadata_arbiter with a 2-cycle BRAM model.
module tb_metadata_arbiter;
  import metadata_arbiter_pkg::*;

  logic clk;
  logic reset_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   g;
  logic [15:0] bram_s1, bram_s2;

  metadata_arbiter_if bus ();

  metadata_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [11:0] a);
    return (a == 12'h140) ? 16'hA5A5 : {4'hC, a};
  endfunction

  always @(posedge clk) begin
    bram_s1 <= bus.mem_rd_en ? mem_word(bus.mem_addr) : 16'hDEAD;
    bram_s2 <= bram_s1;
  end
  assign bus.mem_rd_data = bram_s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.metadata_request = '0;
    bus.pause            = 1'b0;
    bus.restart          = 1'b0;
    reset_n              = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state and single-lane fetch
    do_reset();
    chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("rst_addr",  32'(bus.mem_addr), 32'd0);
    chk("rst_avail", 32'(bus.metadata_available != '0), 32'd0);
    chk("rst_link",  32'(bus.metadata_link != '0), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    bus.metadata_request[5] = 1'b1;
    tick();
    chk("s_rd_en1", 32'(bus.mem_rd_en), 32'd1);
    chk("s_addr1",  32'(bus.mem_addr), 32'h140);
    chk("s_busy1",  32'(bus.busy), 32'd1);
    tick();
    chk("s_rd_en2", 32'(bus.mem_rd_en), 32'd0);
    chk("s_avail2", 32'(bus.metadata_available[5]), 32'd0);
    tick();
    chk("s_avail3", 32'(bus.metadata_available[5]), 32'd0);
    tick();
    chk("s_avail4", 32'(bus.metadata_available[5]), 32'd1);
    chk("s_link4",  32'(bus.metadata_link[5*16 +: 16]), 32'hA5A5);
    bus.metadata_request[5] = 1'b0;
    tick();
    chk("s_rd_en5", 32'(bus.mem_rd_en), 32'd0);
    chk("s_avail5", 32'(bus.metadata_available[5]), 32'd1);
    chk("s_busy5",  32'(bus.busy), 32'd0);

    // Fairness: all lanes held for 74 grants
    do_reset();
    bus.metadata_request = '1;
    g = 0;
    for (int cyc = 0; cyc < 300 && g < 74; cyc++) begin
      tick();
      if (bus.mem_rd_en) begin
        chk("fair_addr", 32'(bus.mem_addr), 32'(((g % 37) << 6) | (g / 37)));
        g++;
        if (g == 74) bus.metadata_request = '0;
      end
    end
    chk("fair_grants", 32'(g), 32'd74);
    g = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      tick();
      if (bus.mem_rd_en) g++;
    end
    chk("fair_quiet", 32'(g), 32'd0);
    bus.metadata_request[0]  = 1'b1;
    bus.metadata_request[36] = 1'b1;
    tick();
    chk("fair_ptr0",  32'(bus.mem_addr), 32'h002);
    bus.metadata_request[0] = 1'b0;
    tick();
    chk("fair_ptr36", 32'(bus.mem_addr), 32'h902);
    bus.metadata_request = '0;

    // Pointer wrap on lane 3
    do_reset();
    bus.metadata_request[3] = 1'b1;
    g = 0;
    for (int cyc = 0; cyc < 400 && g < 65; cyc++) begin
      tick();
      if (bus.mem_rd_en) begin
        chk("wrap_addr", 32'(bus.mem_addr), 32'(12'h0C0 + (g % 64)));
        g++;
        if (g == 65) bus.metadata_request[3] = 1'b0;
      end
    end
    chk("wrap_reads", 32'(g), 32'd65);

    // Pause after lane 7's grant
    do_reset();
    bus.metadata_request[7] = 1'b1;
    bus.metadata_request[8] = 1'b1;
    tick();
    chk("p_rd_en1", 32'(bus.mem_rd_en), 32'd1);
    chk("p_addr1",  32'(bus.mem_addr), 32'h1C0);
    bus.pause = 1'b1;
    tick();
    chk("p_rd_en2", 32'(bus.mem_rd_en), 32'd0);
    tick();
    chk("p_rd_en3", 32'(bus.mem_rd_en), 32'd0);
    tick();
    chk("p_rd_en4", 32'(bus.mem_rd_en), 32'd0);
    chk("p_avail7", 32'(bus.metadata_available[7]), 32'd1);
    chk("p_link7",  32'(bus.metadata_link[7*16 +: 16]), 32'hC1C0);
    bus.metadata_request[7] = 1'b0;
    tick();
    chk("p_rd_en5", 32'(bus.mem_rd_en), 32'd0);
    bus.pause = 1'b0;
    tick();
    chk("p_rd_en6", 32'(bus.mem_rd_en), 32'd0);
    tick();
    chk("p_rd_en7", 32'(bus.mem_rd_en), 32'd1);
    chk("p_addr8",  32'(bus.mem_addr), 32'h200);
    bus.metadata_request[8] = 1'b0;

    // Restart one cycle after lane 2's grant
    do_reset();
    bus.metadata_request[2] = 1'b1;
    tick();
    chk("r_addr1", 32'(bus.mem_addr), 32'h080);
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    chk("r_busy2",  32'(bus.busy), 32'd1);
    chk("r_rd_en2", 32'(bus.mem_rd_en), 32'd0);
    tick();
    chk("r_busy3",  32'(bus.busy), 32'd1);
    tick();
    chk("r_busy4",  32'(bus.busy), 32'd1);
    chk("r_avail4", 32'(bus.metadata_available[2]), 32'd0);
    tick();
    chk("r_busy5",  32'(bus.busy), 32'd0);
    chk("r_avail5", 32'(bus.metadata_available[2]), 32'd0);
    tick();
    chk("r_rd_en6", 32'(bus.mem_rd_en), 32'd1);
    chk("r_addr6",  32'(bus.mem_addr), 32'h080);
    repeat (3) tick();
    chk("r_avail9", 32'(bus.metadata_available[2]), 32'd1);
    chk("r_link9",  32'(bus.metadata_link[2*16 +: 16]), 32'hC080);
    bus.metadata_request[2] = 1'b0;

    // Async reset with a read in flight
    do_reset();
    bus.metadata_request[0]  = 1'b1;
    bus.metadata_request[10] = 1'b1;
    repeat (4) tick();
    chk("a_avail0_pre", 32'(bus.metadata_available[0]), 32'd1);
    chk("a_busy_pre",   32'(bus.busy), 32'd1);
    bus.metadata_request = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("a_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("a_addr",  32'(bus.mem_addr), 32'd0);
    chk("a_avail", 32'(bus.metadata_available != '0), 32'd0);
    chk("a_link",  32'(bus.metadata_link != '0), 32'd0);
    chk("a_busy",  32'(bus.busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus.metadata_request[0]  = 1'b1;
    bus.metadata_request[36] = 1'b1;
    tick();
    chk("a_first_en",   32'(bus.mem_rd_en), 32'd1);
    chk("a_first_addr", 32'(bus.mem_addr), 32'h000);
    bus.metadata_request[0] = 1'b0;
    tick();
    chk("a_second_addr", 32'(bus.mem_addr), 32'h900);
    bus.metadata_request = '0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
